// File: rtl/zxuno_regs_pkg.sv
// ----------------------------------------------------------------------------
// zxuno_regs_pkg
// Shared definitions for the ZX-UNO register-file clients.
//   - Register numbers of the low register map ($00-$04).
//   - State encoding of the flash SPI byte engine.
// No ports (package).
// ----------------------------------------------------------------------------
package zxuno_regs_pkg;

    localparam logic [7:0] REG_MASTERCONF   = 8'h00;
    localparam logic [7:0] REG_MASTERMAPPER = 8'h01;
    localparam logic [7:0] REG_SPIDATA      = 8'h02;
    localparam logic [7:0] REG_SPICS        = 8'h03;
    localparam logic [7:0] REG_SCANCODE     = 8'h04;

    // Byte sent when the CPU only wants to clock data in (read-ahead).
    localparam logic [7:0] SPI_DUMMY_BYTE   = 8'hFF;

    typedef enum logic [1:0] {
        SPI_IDLE = 2'd0,
        SPI_LOW  = 2'd1,
        SPI_HIGH = 2'd2
    } spi_state_t;

endpackage

// File: rtl/spi_byte_engine.sv
// ----------------------------------------------------------------------------
// spi_byte_engine
// Shifts one byte out on MOSI and one byte in from MISO, SPI mode 0, MSB
// first. Each SCK half-period lasts CLKDIV clk cycles.
// Ports:
//   clk, rst_n  system clock, synchronous active-low reset
//   start       one-clk request; ignored unless the engine is idle
//   tx[7:0]     byte to send, sampled together with start
//   rx[7:0]     last completed received byte (stable during a transfer)
//   busy        transfer in progress
//   sck, mosi   SPI clock and data out
//   miso        SPI data in
// ----------------------------------------------------------------------------
module spi_byte_engine
    import zxuno_regs_pkg::*;
#(
    parameter int CLKDIV = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] tx,
    output logic [7:0] rx,
    output logic       busy,
    output logic       sck,
    output logic       mosi,
    input  logic       miso
);

    localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);

    spi_state_t    r_state, w_state_nx;
    logic [DW-1:0] r_div,   w_div_nx;
    logic [2:0]    r_bit,   w_bit_nx;
    logic [7:0]    r_tx_sh, w_tx_sh_nx;
    logic [7:0]    r_rx_sh, w_rx_sh_nx;
    logic [7:0]    r_rx,    w_rx_nx;
    logic          r_busy,  w_busy_nx;
    logic          r_sck,   w_sck_nx;
    logic          r_mosi,  w_mosi_nx;
    logic          w_phase_end;

    assign w_phase_end = (r_div == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= SPI_IDLE;
            r_div   <= '0;
            r_bit   <= 3'd0;
            r_tx_sh <= 8'h00;
            r_rx_sh <= 8'h00;
            r_rx    <= 8'hFF;
            r_busy  <= 1'b0;
            r_sck   <= 1'b0;
            r_mosi  <= 1'b1;
        end else begin
            r_state <= w_state_nx;
            r_div   <= w_div_nx;
            r_bit   <= w_bit_nx;
            r_tx_sh <= w_tx_sh_nx;
            r_rx_sh <= w_rx_sh_nx;
            r_rx    <= w_rx_nx;
            r_busy  <= w_busy_nx;
            r_sck   <= w_sck_nx;
            r_mosi  <= w_mosi_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_div_nx   = r_div;
        w_bit_nx   = r_bit;
        w_tx_sh_nx = r_tx_sh;
        w_rx_sh_nx = r_rx_sh;
        w_rx_nx    = r_rx;
        w_busy_nx  = r_busy;
        w_sck_nx   = r_sck;
        w_mosi_nx  = r_mosi;
        case (r_state)
            SPI_IDLE: begin
                if (start) begin
                    // First data bit must be on MOSI before the first SCK rise.
                    w_state_nx = SPI_LOW;
                    w_busy_nx  = 1'b1;
                    w_mosi_nx  = tx[7];
                    w_tx_sh_nx = tx;
                    w_div_nx   = '0;
                    w_bit_nx   = 3'd0;
                end
            end
            SPI_LOW: begin
                if (w_phase_end) begin
                    // Flash drives MISO on the falling edge; sample it on the rise.
                    w_state_nx = SPI_HIGH;
                    w_sck_nx   = 1'b1;
                    w_rx_sh_nx = {r_rx_sh[6:0], miso};
                    w_div_nx   = '0;
                end else begin
                    w_div_nx = r_div + 1'b1;
                end
            end
            SPI_HIGH: begin
                if (w_phase_end) begin
                    w_sck_nx = 1'b0;
                    w_div_nx = '0;
                    w_bit_nx = r_bit + 3'd1;  // wraps 7 -> 0 on the way to idle
                    if (r_bit == 3'd7) begin
                        w_state_nx = SPI_IDLE;
                        w_rx_nx    = r_rx_sh;
                        w_busy_nx  = 1'b0;
                        w_mosi_nx  = 1'b1;
                    end else begin
                        w_state_nx = SPI_LOW;
                        w_mosi_nx  = r_tx_sh[6];
                        w_tx_sh_nx = {r_tx_sh[6:0], 1'b0};
                    end
                end else begin
                    w_div_nx = r_div + 1'b1;
                end
            end
            default: begin
                w_state_nx = SPI_IDLE;
            end
        endcase
    end

    assign rx   = r_rx;
    assign busy = r_busy;
    assign sck  = r_sck;
    assign mosi = r_mosi;

endmodule

// File: rtl/flash_spi_master.sv
// ----------------------------------------------------------------------------
// flash_spi_master
// ZX-UNO register client for the boot/config flash: register SPIDATA moves
// one SPI byte per CPU access, register SPICS drives the chip select.
// Ports:
//   clk, rst_n      system clock, synchronous active-low reset
//   addr[7:0]       register number from the address decoder
//   read_from_reg   level, CPU read of the selected register in progress
//   write_to_reg    level, CPU write of the selected register in progress
//   din[7:0]        CPU write data (valid while write_to_reg=1)
//   dout[7:0]       read data, high impedance when oe_n=1
//   oe_n            low while this block drives dout
//   spi_clk, spi_do SCK and MOSI to the flash
//   spi_di          MISO from the flash
//   spi_cs_n        flash chip select, active-low
//   busy            byte transfer in progress
//
// Access protocol: read_from_reg/write_to_reg are levels lasting several clk.
// A write acts once, on its rising edge; a SPIDATA read returns the last
// received byte while the level is high and, on its falling edge, starts a
// dummy 8'hFF transfer so the next read finds a fresh byte. Starts that
// arrive while busy are dropped; software polls busy through SPICS.
// ----------------------------------------------------------------------------
module flash_spi_master
    import zxuno_regs_pkg::*;
#(
    parameter logic [7:0] SPIDATA = REG_SPIDATA,
    parameter logic [7:0] SPICS   = REG_SPICS,
    parameter int         CLKDIV  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] addr,
    input  logic       read_from_reg,
    input  logic       write_to_reg,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       oe_n,
    output logic       spi_clk,
    output logic       spi_do,
    input  logic       spi_di,
    output logic       spi_cs_n,
    output logic       busy
);

    logic       r_wr_q;
    logic       r_rd_q;
    logic [7:0] r_rd_addr;
    logic       r_cs_n;

    logic       w_wstart;
    logic       w_rend;
    logic       w_start;
    logic [7:0] w_tx;
    logic [7:0] w_rx;
    logic       w_busy;
    logic       w_oe_n;
    logic [7:0] w_rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_q    <= 1'b0;
            r_rd_q    <= 1'b0;
            r_rd_addr <= 8'h00;
            r_cs_n    <= 1'b1;
        end else begin
            r_wr_q <= write_to_reg;
            r_rd_q <= read_from_reg;
            // Hold the register number of the read so the falling edge still
            // knows which port was read after the decoder has moved on.
            if (read_from_reg) begin
                r_rd_addr <= addr;
            end
            // Chip select follows the CPU at once, even mid-transfer.
            if (w_wstart && (addr == SPICS)) begin
                r_cs_n <= ~din[0];
            end
        end
    end

    assign w_wstart = write_to_reg & ~r_wr_q;
    assign w_rend   = ~read_from_reg & r_rd_q;

    // A write edge wins over a coincident read end; the read-ahead is lost.
    assign w_start = (w_wstart && (addr == SPIDATA)) ||
                     (!w_wstart && w_rend && (r_rd_addr == SPIDATA));
    assign w_tx    = w_wstart ? din : SPI_DUMMY_BYTE;

    spi_byte_engine #(
        .CLKDIV (CLKDIV)
    ) u_engine (
        .clk   (clk),
        .rst_n (rst_n),
        .start (w_start),
        .tx    (w_tx),
        .rx    (w_rx),
        .busy  (w_busy),
        .sck   (spi_clk),
        .mosi  (spi_do),
        .miso  (spi_di)
    );

    always_comb begin
        w_oe_n  = 1'b1;
        w_rdata = 8'h00;
        if (read_from_reg) begin
            if (addr == SPIDATA) begin
                w_oe_n  = 1'b0;
                w_rdata = w_rx;
            end else if (addr == SPICS) begin
                w_oe_n  = 1'b0;
                w_rdata = {w_busy, 6'b000000, ~r_cs_n};
            end
        end
    end

    assign oe_n     = w_oe_n;
    assign dout     = w_oe_n ? 8'hzz : w_rdata;
    assign spi_cs_n = r_cs_n;
    assign busy     = w_busy;

endmodule

// File: tb/tb_flash_spi_master.sv
// ----------------------------------------------------------------------------
// tb_flash_spi_master
// Bench for flash_spi_master with CLKDIV=2. A small flash model answers on
// MISO; MOSI bytes and read data are checked against expected queues.
// ----------------------------------------------------------------------------
module tb_flash_spi_master;

    localparam logic [7:0] SPIDATA = 8'h02;
    localparam logic [7:0] SPICS   = 8'h03;
    localparam int         CLKDIV  = 2;
    localparam int         XFER_CLK = 16 * CLKDIV;

    logic       clk;
    logic       rst_n;
    logic [7:0] addr;
    logic       read_from_reg;
    logic       write_to_reg;
    logic [7:0] din;
    wire  [7:0] dout;
    wire        oe_n;
    wire        spi_clk;
    wire        spi_do;
    logic       spi_di;
    wire        spi_cs_n;
    wire        busy;

    flash_spi_master #(
        .SPIDATA (SPIDATA),
        .SPICS   (SPICS),
        .CLKDIV  (CLKDIV)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .addr          (addr),
        .read_from_reg (read_from_reg),
        .write_to_reg  (write_to_reg),
        .din           (din),
        .dout          (dout),
        .oe_n          (oe_n),
        .spi_clk       (spi_clk),
        .spi_do        (spi_do),
        .spi_di        (spi_di),
        .spi_cs_n      (spi_cs_n),
        .busy          (busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int         n_vec     = 0;
    int         n_miscmp  = 0;
    logic [7:0] exp_mosi_q[$];
    logic [7:0] exp_rd_q[$];
    logic [7:0] model_rx;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- flash model ----------------
    logic [7:0] flash_byte = 8'h00;
    logic [2:0] fall_cnt;
    logic [2:0] rise_cnt;
    logic [7:0] mosi_cap;
    int         sck_rises = 0;

    // MISO changes after each SCK fall, first bit presented before the burst.
    always @(negedge spi_clk or negedge rst_n) begin
        if (!rst_n) fall_cnt <= 3'd0;
        else        fall_cnt <= fall_cnt + 3'd1;
    end
    assign spi_di = flash_byte[3'd7 - fall_cnt];

    always @(posedge spi_clk) sck_rises++;

    always @(posedge spi_clk or negedge rst_n) begin
        logic [7:0] cap;
        if (!rst_n) begin
            rise_cnt = 3'd0;
            mosi_cap = 8'h00;
        end else begin
            cap      = {mosi_cap[6:0], spi_do};
            mosi_cap = cap;
            rise_cnt = rise_cnt + 3'd1;
            if (rise_cnt == 3'd0) begin
                if (exp_mosi_q.size() == 0) check("mosi_unexpected_burst", {24'd0, cap}, 32'hFFFF_FFFF);
                else                       check("mosi_byte", {24'd0, cap}, {24'd0, exp_mosi_q.pop_front()});
            end
        end
    end

    // Length of the most recent busy pulse, in clk cycles.
    int busy_run = 0;
    int last_busy_len = 0;
    always @(negedge clk) begin
        if (!rst_n)        busy_run = 0;
        else if (busy)     busy_run++;
        else if (busy_run != 0) begin
            last_busy_len = busy_run;
            busy_run      = 0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic reg_write(input logic [7:0] a, input logic [7:0] d, output logic cs_after);
        @(negedge clk);
        addr = a; din = d; write_to_reg = 1'b1;
        @(negedge clk);
        cs_after = spi_cs_n;
        repeat (2) @(negedge clk);
        write_to_reg = 1'b0;
        @(negedge clk);
    endtask

    task automatic reg_read(input logic [7:0] a, input string tag);
        @(negedge clk);
        addr = a; read_from_reg = 1'b1;
        @(negedge clk);
        if (a == SPIDATA || a == SPICS) begin
            check({tag, "_oe"}, {31'd0, oe_n}, 32'd0);
            if (exp_rd_q.size() == 0) check({tag, "_no_expect"}, 32'd1, 32'd0);
            else                     check(tag, {24'd0, dout}, {24'd0, exp_rd_q.pop_front()});
        end else begin
            check({tag, "_oe"}, {31'd0, oe_n}, 32'd1);
        end
        repeat (2) @(negedge clk);
        read_from_reg = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle_timeout"}, {31'd0, busy}, 32'd0);
        @(negedge clk);
    endtask

    // One write to SPIDATA with full checking of the resulting burst.
    task automatic byte_xfer(input logic [7:0] tx, input logic [7:0] resp, input string tag);
        int   s0;
        logic cs_dummy;
        flash_byte = resp;
        exp_mosi_q.push_back(tx);
        s0 = sck_rises;
        reg_write(SPIDATA, tx, cs_dummy);
        wait_idle(tag);
        check({tag, "_pulses"}, sck_rises - s0, 8);
        check({tag, "_busy_len"}, last_busy_len, XFER_CLK);
        model_rx = resp;
    endtask

    // Read SPIDATA and let its read-ahead complete with the given flash byte.
    task automatic read_stream(input logic [7:0] next_resp, input string tag);
        int s0;
        exp_rd_q.push_back(model_rx);
        flash_byte = next_resp;
        exp_mosi_q.push_back(8'hFF);
        s0 = sck_rises;
        reg_read(SPIDATA, tag);
        wait_idle(tag);
        check({tag, "_ra_pulses"}, sck_rises - s0, 8);
        model_rx = next_resp;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic cs_after;
        int   s0;
        int   n;
        rst_n = 1'b0; addr = 8'h00; din = 8'h00;
        read_from_reg = 1'b0; write_to_reg = 1'b0;
        model_rx = 8'hFF;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_cs_n", {31'd0, spi_cs_n}, 32'd1);
        check("rst_sck", {31'd0, spi_clk}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_mosi", {31'd0, spi_do}, 32'd1);
        read_stream(8'h00, "rst_rx");

        // Unmapped register: no drive, no burst
        s0 = sck_rises;
        reg_read(8'h04, "other_reg");
        repeat (4) @(negedge clk);
        check("other_reg_no_burst", sck_rises - s0, 0);

        // Chip select
        reg_write(SPICS, 8'h01, cs_after);
        check("cs_low_next_clk", {31'd0, cs_after}, 32'd0);
        exp_rd_q.push_back(8'h01);
        reg_read(SPICS, "cs_status_low");
        reg_write(SPICS, 8'h00, cs_after);
        check("cs_high_next_clk", {31'd0, cs_after}, 32'd1);
        reg_write(SPICS, 8'h01, cs_after);

        // Byte out/in
        byte_xfer(8'hA5, 8'h3C, "a5");

        // Read-ahead with a mid-transfer read of both ports
        exp_rd_q.push_back(model_rx);
        flash_byte = 8'h5A;
        exp_mosi_q.push_back(8'hFF);
        s0 = sck_rises;
        reg_read(SPIDATA, "ra_first");
        check("ra_busy_started", {31'd0, busy}, 32'd1);
        exp_rd_q.push_back(8'h3C);
        reg_read(SPIDATA, "ra_mid_xfer");
        exp_rd_q.push_back(8'h81);
        reg_read(SPICS, "cs_status_busy");
        wait_idle("ra");
        check("ra_single_burst", sck_rises - s0, 8);
        model_rx = 8'h5A;
        read_stream(8'hC3, "ra_second");

        // Busy collision: second write is dropped
        flash_byte = 8'h11;
        exp_mosi_q.push_back(8'h9F);
        s0 = sck_rises;
        reg_write(SPIDATA, 8'h9F, cs_after);
        reg_write(SPIDATA, 8'h00, cs_after);
        wait_idle("collide");
        repeat (4) @(negedge clk);
        check("collide_pulses", sck_rises - s0, 8);
        model_rx = 8'h11;
        read_stream(8'hE7, "collide_rx");

        // Random bytes
        for (int i = 0; i < 4; i++) begin
            byte_xfer(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), "rand");
            read_stream(8'($urandom_range(0, 255)), "rand_rx");
        end

        // Abort at bit 4
        flash_byte = 8'h77;
        s0 = sck_rises;
        reg_write(SPIDATA, 8'h66, cs_after);
        n = 0;
        while ((sck_rises - s0) < 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("abort_reach_bit4", sck_rises - s0, 5);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_sck", {31'd0, spi_clk}, 32'd0);
        check("abort_cs_n", {31'd0, spi_cs_n}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_mosi", {31'd0, spi_do}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        model_rx = 8'hFF;
        read_stream(8'h00, "abort_rx");

        check("mosi_queue_empty", exp_mosi_q.size(), 0);
        check("rd_queue_empty", exp_rd_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #500000;
        n_miscmp++;
        $display("FAIL global_timeout: got running expected finished");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
